esc_sensor_frontend: RTL and testbench



---
 rtl/esc_sensor_frontend.sv | 166 ++++++++++++++++
 tb/tb_esc_sensor_frontend.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/esc_sensor_frontend.sv
// Landing-sensor / e-stop input conditioning: 2-flop sync, tick-strobed debounce, occupancy counter.
// Optional: define ESTOP_CLR_OCC_EN to clear occupancy and occ_err when the e-stop asserts.
module esc_sensor_frontend #(
  parameter int DEB_TICKS = 4,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             tick,
  input  logic             sensor_bot_raw,
  input  logic             sensor_top_raw,
  input  logic             estop_n_raw,
  output logic             bot_lvl,
  output logic             top_lvl,
  output logic             bot_stb,
  output logic             top_stb,
  output logic             estop_act,
  output logic [CNT_W-1:0] occupancy,
  output logic             occ_full,
  output logic             occ_err
);

  localparam int              DW       = 4;
  localparam logic [DW-1:0]   DEB_LAST = DW'(DEB_TICKS - 1);
  localparam logic [CNT_W-1:0] OCC_MAX = '1;

  // bit 0 = bottom sensor, bit 1 = top sensor, bit 2 = estop_n
  logic [2:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= {estop_n_raw, sensor_top_raw, sensor_bot_raw};
      sync2_q <= sync1_q;
    end
  end

  logic [1:0] lvl_vec, stb_vec;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_deb
      logic          lvl_q, lvl_d, stb_q, stb_d;
      logic [DW-1:0] cnt_q, cnt_d;

      always_comb begin
        lvl_d = lvl_q;
        stb_d = 1'b0;
        cnt_d = cnt_q;
        if (ena) begin
          if (sync2_q[gi] == lvl_q) begin
            cnt_d = '0;
          end else if (tick) begin
            if (cnt_q == DEB_LAST) begin
              lvl_d = sync2_q[gi];
              stb_d = sync2_q[gi];
              cnt_d = '0;
            end else begin
              cnt_d = cnt_q + 1'b1;
            end
          end
        end
      end

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          lvl_q <= 1'b0;
          stb_q <= 1'b0;
          cnt_q <= '0;
        end else begin
          lvl_q <= lvl_d;
          stb_q <= stb_d;
          cnt_q <= cnt_d;
        end
      end

      assign lvl_vec[gi] = lvl_q;
      assign stb_vec[gi] = stb_q;
    end
  endgenerate

  assign bot_lvl = lvl_vec[0];
  assign top_lvl = lvl_vec[1];
  assign bot_stb = stb_vec[0] & ena;
  assign top_stb = stb_vec[1] & ena;

  // E-stop asserts immediately (even with ena low); release is debounced.
  logic          estop_act_q, estop_act_d;
  logic [DW-1:0] ecnt_q, ecnt_d;

  always_comb begin
    estop_act_d = estop_act_q;
    ecnt_d      = ecnt_q;
    if (!sync2_q[2]) begin
      estop_act_d = 1'b1;
      ecnt_d      = '0;
    end else if (ena) begin
      if (!estop_act_q) begin
        ecnt_d = '0;
      end else if (tick) begin
        if (ecnt_q == DEB_LAST) begin
          estop_act_d = 1'b0;
          ecnt_d      = '0;
        end else begin
          ecnt_d = ecnt_q + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      estop_act_q <= 1'b1;
      ecnt_q      <= '0;
    end else begin
      estop_act_q <= estop_act_d;
      ecnt_q      <= ecnt_d;
    end
  end

  assign estop_act = estop_act_q;

  logic clr_occ;
`ifdef ESTOP_CLR_OCC_EN
  assign clr_occ = estop_act_d & ~estop_act_q;
`else
  assign clr_occ = 1'b0;
`endif

  logic [CNT_W-1:0] occ_q, occ_d;
  logic             err_q, err_d;

  always_comb begin
    occ_d = occ_q;
    err_d = err_q;
    if (clr_occ) begin
      occ_d = '0;
      err_d = 1'b0;
    end else if (ena) begin
      if (bot_stb && !top_stb) begin
        if (occ_q != OCC_MAX) occ_d = occ_q + 1'b1;
      end else if (top_stb && !bot_stb) begin
        if (occ_q == '0) err_d = 1'b1;
        else             occ_d = occ_q - 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      occ_q <= '0;
      err_q <= 1'b0;
    end else begin
      occ_q <= occ_d;
      err_q <= err_d;
    end
  end

  assign occupancy = occ_q;
  assign occ_full  = (occ_q == OCC_MAX);
  assign occ_err   = err_q;

endmodule

// File: tb/tb_esc_sensor_frontend.sv
// Scoreboard bench for esc_sensor_frontend: expected strobe/occupancy results queued at stimulus time.
module tb_esc_sensor_frontend;

  logic       clk, rst_n, ena, tick;
  logic       sensor_bot_raw, sensor_top_raw, estop_n_raw;
  logic       bot_lvl, top_lvl, bot_stb, top_stb, estop_act, occ_full, occ_err;
  logic [3:0] occupancy;

  esc_sensor_frontend #(.DEB_TICKS(4), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .ena(ena), .tick(tick),
    .sensor_bot_raw(sensor_bot_raw), .sensor_top_raw(sensor_top_raw),
    .estop_n_raw(estop_n_raw),
    .bot_lvl(bot_lvl), .top_lvl(top_lvl), .bot_stb(bot_stb), .top_stb(top_stb),
    .estop_act(estop_act), .occupancy(occupancy), .occ_full(occ_full), .occ_err(occ_err)
  );

  typedef struct { bit b; bit t; int occ; bit err; } exp_t;
  exp_t sb_q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int occ_m    = 0;
  bit err_m    = 0;
  bit pend     = 0;
  exp_t pend_e;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    tick = 1'b0;
    forever begin
      repeat (9) @(negedge clk);
      tick = 1'b1;
      @(negedge clk);
      tick = 1'b0;
    end
  end

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
    end
  endtask

  task automatic next_tick();
    int n = 0;
    do begin
      @(posedge clk);
      n++;
    end while (tick !== 1'b1 && n < 20);
    #1;
  endtask

  task automatic push_exp(input bit b, input bit t);
    exp_t e;
    if (b && !t) begin
      if (occ_m < 15) occ_m++;
    end else if (t && !b) begin
      if (occ_m == 0) err_m = 1'b1;
      else            occ_m--;
    end
    e.b = b; e.t = t; e.occ = occ_m; e.err = err_m;
    sb_q.push_back(e);
  endtask

  // Drive one debounced arrival (bottom, top or both); must be entered just after a tick.
  task automatic do_entry(input bit b, input bit t, input string tag);
    int rise = 0;
    push_exp(b, t);
    sensor_bot_raw = b;
    sensor_top_raw = t;
    for (int i = 1; i <= 5; i++) begin
      next_tick();
      if (rise == 0 && ((b && bot_lvl) || (t && top_lvl))) rise = i;
    end
    check_val({tag, "_rise_tick"}, rise, 4);
    sensor_bot_raw = 1'b0;
    sensor_top_raw = 1'b0;
    repeat (5) next_tick();
    check_val({tag, "_fall"}, {bot_lvl, top_lvl}, 0);
  endtask

  // Monitor: pop an expectation on every strobe, check occupancy the following cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (pend) begin
          check_val("occ_after_stb", occupancy, pend_e.occ);
          check_val("err_after_stb", occ_err, pend_e.err);
          check_val("stb_width", {bot_stb, top_stb}, 0);
          $display("txn b=%0b t=%0b occ=%0d err=%0b", pend_e.b, pend_e.t, occupancy, occ_err);
          pend = 1'b0;
        end else if (bot_stb || top_stb) begin
          if (sb_q.size() == 0) begin
            check_val("unexpected_stb", {bot_stb, top_stb}, 0);
          end else begin
            e = sb_q.pop_front();
            check_val("stb_kind", {bot_stb, top_stb}, {e.b, e.t});
            pend_e = e;
            pend   = 1'b1;
          end
        end
      end
    end
  end

  initial begin
    int rel;
    int lat;
    rst_n = 1'b0; ena = 1'b1;
    sensor_bot_raw = 1'b0; sensor_top_raw = 1'b0; estop_n_raw = 1'b1;

    // 1: reset state and e-stop release after 4 ticks
    #7;
    check_val("rst_estop_act", estop_act, 1);
    check_val("rst_outputs", {bot_lvl, top_lvl, bot_stb, top_stb, occ_full, occ_err}, 0);
    check_val("rst_occupancy", occupancy, 0);
    #5 rst_n = 1'b1;
    rel = 0;
    for (int i = 1; i <= 6; i++) begin
      next_tick();
      if (rel == 0 && !estop_act) rel = i;
    end
    check_val("estop_release_ticks", rel, 4);
    check_val("idle_outputs", {bot_lvl, top_lvl, occ_full, occ_err}, 0);

    // 2: one bottom entry
    do_entry(1'b1, 1'b0, "bot1");
    check_val("occ_after_bot1", occupancy, 1);

    // 3: top glitch then a clean top arrival
    push_exp(1'b0, 1'b1);
    sensor_top_raw = 1'b1;
    next_tick(); next_tick();
    sensor_top_raw = 1'b0;
    next_tick();
    check_val("glitch_lvl", top_lvl, 0);
    sensor_top_raw = 1'b1;
    repeat (3) next_tick();
    check_val("glitch_early", top_lvl, 0);
    next_tick();
    check_val("glitch_rise", top_lvl, 1);
    sensor_top_raw = 1'b0;
    repeat (5) next_tick();
    check_val("occ_after_top", occupancy, 0);

    // 4: saturate at 15
    for (int i = 1; i <= 16; i++) begin
      do_entry(1'b1, 1'b0, "sat");
      if (i == 15) check_val("occ_full_15", occ_full, 1);
    end
    check_val("occ_sat", occupancy, 15);
    check_val("occ_full_sat", occ_full, 1);

    // Reset mid-operation
    rst_n = 1'b0;
    @(negedge clk); @(negedge clk);
    check_val("midrst_occ", occupancy, 0);
    check_val("midrst_estop", estop_act, 1);
    check_val("midrst_flags", {occ_full, occ_err, bot_stb, top_stb}, 0);
    rst_n = 1'b1;
    occ_m = 0; err_m = 1'b0;
    rel = 0;
    for (int i = 1; i <= 6; i++) begin
      next_tick();
      if (rel == 0 && !estop_act) rel = i;
    end
    check_val("estop_release_midrst", rel, 4);

    // 5: underflow error, then simultaneous strobes
    do_entry(1'b0, 1'b1, "underflow");
    check_val("occ_err_set", occ_err, 1);
    check_val("occ_underflow", occupancy, 0);
    do_entry(1'b1, 1'b1, "both");
    check_val("occ_both", occupancy, 0);
    check_val("occ_err_sticky", occ_err, 1);

    // 6: occupancy 3, short e-stop pulse
    repeat (3) do_entry(1'b1, 1'b0, "to3");
    check_val("occ_3", occupancy, 3);
    @(negedge clk);
    estop_n_raw = 1'b0;
    lat = 0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (i == 1) estop_n_raw = 1'b1;
      if (lat == 0 && estop_act) lat = i;
    end
    check_val("estop_latency", lat, 3);
`ifdef ESTOP_CLR_OCC_EN
    occ_m = 0; err_m = 1'b0;
`endif
    check_val("estop_occ", occupancy, occ_m);
    check_val("estop_err", occ_err, err_m);
    repeat (6) next_tick();
    check_val("estop_released", estop_act, 0);

    // e-stop honoured with ena low; everything else frozen
    ena = 1'b0;
    @(negedge clk);
    estop_n_raw = 1'b0;
    lat = 0;
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      if (i == 1) estop_n_raw = 1'b1;
      if (lat == 0 && estop_act) lat = i;
    end
    check_val("estop_latency_ena0", lat, 3);
`ifdef ESTOP_CLR_OCC_EN
    occ_m = 0; err_m = 1'b0;
`endif
    sensor_bot_raw = 1'b1;
    repeat (5) next_tick();
    check_val("ena0_lvl_hold", bot_lvl, 0);
    check_val("ena0_estop_hold", estop_act, 1);
    check_val("ena0_occ", occupancy, occ_m);
    check_val("ena0_err", occ_err, err_m);
    sensor_bot_raw = 1'b0;
    repeat (3) @(posedge clk);
    #1 ena = 1'b1;
    rel = 0;
    for (int i = 1; i <= 6; i++) begin
      next_tick();
      if (rel == 0 && !estop_act) rel = i;
    end
    check_val("estop_release_after_ena", rel, 4);
    check_val("final_occ", occupancy, occ_m);

    repeat (3) @(negedge clk);
    check_val("scoreboard_drained", sb_q.size() + int'(pend), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
